// File: rtl/bsg_cache_dma_scheduler_pkg.sv
// Shared helpers and state encoding for the cache DMA scheduler.
// A DMA packet is {write_not_read, addr}, so write_not_read is the packet MSB.
package bsg_cache_dma_scheduler_pkg;

  function automatic int safe_clog2(input int x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

  function automatic int dma_pkt_width(input int addr_width);
    return addr_width + 1;
  endfunction

  typedef enum logic {
    e_idle  = 1'b0,
    e_grant = 1'b1
  } sched_state_e;

endpackage

// File: rtl/bsg_cache_dma_scheduler_if.sv
// Cache-side and bridge-side DMA packet handshakes plus read-data monitor taps.
interface bsg_cache_dma_scheduler_if
  import bsg_cache_dma_scheduler_pkg::*;
#(
  parameter int num_cache_p     = 4,
  parameter int dma_pkt_width_p = dma_pkt_width(32)
);

  logic [num_cache_p-1:0][dma_pkt_width_p-1:0] dma_pkt_i;
  logic [num_cache_p-1:0]                      dma_pkt_v_i;
  logic [num_cache_p-1:0]                      dma_pkt_yumi_o;
  logic [num_cache_p-1:0][dma_pkt_width_p-1:0] dma_pkt_o;
  logic [num_cache_p-1:0]                      dma_pkt_v_o;
  logic [num_cache_p-1:0]                      dma_pkt_yumi_i;
  logic [num_cache_p-1:0]                      dma_data_v_i;
  logic [num_cache_p-1:0]                      dma_data_ready_i;

  modport slave (
    input  dma_pkt_i, dma_pkt_v_i, dma_pkt_yumi_i, dma_data_v_i, dma_data_ready_i,
    output dma_pkt_yumi_o, dma_pkt_o, dma_pkt_v_o
  );

  modport master (
    output dma_pkt_i, dma_pkt_v_i, dma_pkt_yumi_i, dma_data_v_i, dma_data_ready_i,
    input  dma_pkt_yumi_o, dma_pkt_o, dma_pkt_v_o
  );

endinterface

// File: rtl/bsg_cache_dma_credit_counter.sv
// Up/down outstanding-transaction counter; decrements beyond the current count
// are clipped to zero and flagged, and the accepted decrement is reported.
module bsg_cache_dma_credit_counter #(
  parameter int width_p     = 2,
  parameter int dec_width_p = 2
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   inc_i,
  input  logic [dec_width_p-1:0] dec_i,
  output logic [width_p-1:0]     cnt_o,
  output logic [dec_width_p-1:0] dec_ok_o,
  output logic                   err_o
);

  localparam int cw_lp = ((width_p > dec_width_p) ? width_p : dec_width_p) + 1;

  logic [width_p-1:0] cnt_q;
  logic [cw_lp-1:0]   cnt_x, dec_x, ok_x, next_x;

  always_comb begin
    cnt_x    = cw_lp'(cnt_q);
    dec_x    = cw_lp'(dec_i);
    err_o    = dec_x > cnt_x;
    ok_x     = err_o ? cnt_x : dec_x;
    next_x   = cnt_x + cw_lp'(inc_i) - ok_x;
    dec_ok_o = dec_width_p'(ok_x);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) cnt_q <= '0;
    else            cnt_q <= width_p'(next_x);
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/bsg_cache_dma_scheduler.sv
// Round-robin DMA packet scheduler with outstanding limits and write anti-starvation.
//   state   | meaning
//   e_idle  | pick an eligible cache (round-robin from rr_ptr) and latch it
//   e_grant | offer the latched cache's packet to the bridge until yumi
module bsg_cache_dma_scheduler
  import bsg_cache_dma_scheduler_pkg::*;
#(
  parameter int num_cache_p           = 4,
  parameter int addr_width_p          = 32,
  parameter int block_size_in_words_p = 8,
  parameter int max_outstanding_p     = 2,
  parameter int total_outstanding_p   = 4,
  parameter int starve_limit_p        = 4
) (
  input  logic                                clk_i,
  input  logic                                reset_n_i,
  bsg_cache_dma_scheduler_if.slave            dma,
  input  logic                                wr_done_v_i,
  input  logic [safe_clog2(num_cache_p)-1:0]  wr_done_id_i,
  output logic                                error_o
);

  localparam int dma_pkt_width_lp = dma_pkt_width(addr_width_p);
  localparam int id_w_lp     = safe_clog2(num_cache_p);
  localparam int cnt_w_lp    = safe_clog2(max_outstanding_p + 2);
  localparam int tot_w_lp    = safe_clog2(total_outstanding_p + num_cache_p + 2);
  localparam int tdec_w_lp   = safe_clog2(num_cache_p + 2);
  localparam int wcnt_w_lp   = safe_clog2(block_size_in_words_p);
  localparam int streak_w_lp = safe_clog2(starve_limit_p + 1);

  sched_state_e state_q, state_n;
  logic [id_w_lp-1:0]     grant_id_q, grant_id_n, rr_ptr_q, rr_ptr_n, sel_id, cand_id;
  logic                   sel_v, issue, starve_active, id_bad, error_q, total_err;
  logic [streak_w_lp-1:0] rd_streak_q, rd_streak_n;
  logic [num_cache_p-1:0] is_write, elig, beat, rd_done, wr_hit, cnt_err;
  logic [num_cache_p-1:0][cnt_w_lp-1:0]  out_cnt;
  logic [num_cache_p-1:0][1:0]           cache_dec, cache_dec_ok;
  logic [num_cache_p-1:0][wcnt_w_lp-1:0] wcnt_q;
  logic [tot_w_lp-1:0]    total_cnt;
  logic [tdec_w_lp-1:0]   total_dec, total_dec_ok;
  int                     cand;

  assign dma.dma_pkt_o = dma.dma_pkt_i;

  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < num_cache_p; i++) begin
      is_write[i] = dma.dma_pkt_i[i][dma_pkt_width_lp-1];
      beat[i]     = dma.dma_data_v_i[i] & dma.dma_data_ready_i[i];
      rd_done[i]  = beat[i] && (wcnt_q[i] == wcnt_w_lp'(block_size_in_words_p - 1));
      if (wr_done_v_i && (wr_done_id_i == id_w_lp'(i))) wr_hit[i] = 1'b1;
    end
    id_bad = wr_done_v_i & ~(|wr_hit);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wcnt_q <= '0;
    end else begin
      for (int i = 0; i < num_cache_p; i++)
        if (beat[i]) wcnt_q[i] <= rd_done[i] ? '0 : wcnt_q[i] + wcnt_w_lp'(1);
    end
  end

  for (genvar i = 0; i < num_cache_p; i++) begin : g_cache_cnt
    assign cache_dec[i] = 2'(rd_done[i]) + 2'(wr_hit[i]);
    bsg_cache_dma_credit_counter #(.width_p(cnt_w_lp), .dec_width_p(2)) u_cnt (
      .clk_i    (clk_i),
      .reset_n_i(reset_n_i),
      .inc_i    (issue && (grant_id_q == id_w_lp'(i))),
      .dec_i    (cache_dec[i]),
      .cnt_o    (out_cnt[i]),
      .dec_ok_o (cache_dec_ok[i]),
      .err_o    (cnt_err[i])
    );
  end

  // Only completions accepted per cache are retired from the global count.
  always_comb begin
    total_dec = '0;
    for (int i = 0; i < num_cache_p; i++) total_dec = total_dec + tdec_w_lp'(cache_dec_ok[i]);
  end

  bsg_cache_dma_credit_counter #(.width_p(tot_w_lp), .dec_width_p(tdec_w_lp)) u_total (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .inc_i    (issue),
    .dec_i    (total_dec),
    .cnt_o    (total_cnt),
    .dec_ok_o (total_dec_ok),
    .err_o    (total_err)
  );

  always_comb begin
    starve_active = (rd_streak_q == streak_w_lp'(starve_limit_p)) &&
                    (|(dma.dma_pkt_v_i & is_write));
    for (int i = 0; i < num_cache_p; i++)
      elig[i] = dma.dma_pkt_v_i[i]
             && (out_cnt[i] < cnt_w_lp'(max_outstanding_p))
             && (total_cnt < tot_w_lp'(total_outstanding_p))
             && !(starve_active && !is_write[i]);
    sel_v   = 1'b0;
    sel_id  = '0;
    cand    = 0;
    cand_id = '0;
    for (int k = 0; k < num_cache_p; k++) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= num_cache_p) cand = cand - num_cache_p;
      cand_id = id_w_lp'(cand);
      if (!sel_v && elig[cand_id]) begin
        sel_v  = 1'b1;
        sel_id = cand_id;
      end
    end
  end

  always_comb begin
    state_n            = state_q;
    grant_id_n         = grant_id_q;
    rr_ptr_n           = rr_ptr_q;
    rd_streak_n        = rd_streak_q;
    issue              = 1'b0;
    dma.dma_pkt_v_o    = '0;
    dma.dma_pkt_yumi_o = '0;
    case (state_q)
      e_idle: begin
        if (sel_v) begin
          grant_id_n = sel_id;
          state_n    = e_grant;
        end
      end
      e_grant: begin
        dma.dma_pkt_v_o[grant_id_q]    = 1'b1;
        dma.dma_pkt_yumi_o[grant_id_q] = dma.dma_pkt_yumi_i[grant_id_q];
        if (dma.dma_pkt_yumi_i[grant_id_q]) begin
          issue    = 1'b1;
          state_n  = e_idle;
          rr_ptr_n = (grant_id_q == id_w_lp'(num_cache_p - 1)) ? '0 : grant_id_q + id_w_lp'(1);
          if (is_write[grant_id_q])
            rd_streak_n = '0;
          else if (rd_streak_q != streak_w_lp'(starve_limit_p))
            rd_streak_n = rd_streak_q + streak_w_lp'(1);
        end
      end
      default: state_n = e_idle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= e_idle;
      grant_id_q  <= '0;
      rr_ptr_q    <= '0;
      rd_streak_q <= '0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_n;
      grant_id_q  <= grant_id_n;
      rr_ptr_q    <= rr_ptr_n;
      rd_streak_q <= rd_streak_n;
      error_q     <= error_q | (|cnt_err) | total_err | id_bad;
    end
  end

  assign error_o = error_q;

endmodule

// File: tb/tb_bsg_cache_dma_scheduler.sv
// Randomized bench for bsg_cache_dma_scheduler against a transaction-level model.
module tb_bsg_cache_dma_scheduler;
  import bsg_cache_dma_scheduler_pkg::*;

  localparam int N = 4, AW = 32, B = 8, MAXO = 2, TOT = 4, S = 4;
  localparam int PW = AW + 1, IDW = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic wr_v;
  logic [IDW-1:0] wr_id;
  logic error;

  always #5 clk = ~clk;

  bsg_cache_dma_scheduler_if #(.num_cache_p(N), .dma_pkt_width_p(PW)) dma_if ();

  bsg_cache_dma_scheduler #(
    .num_cache_p(N), .addr_width_p(AW), .block_size_in_words_p(B),
    .max_outstanding_p(MAXO), .total_outstanding_p(TOT), .starve_limit_p(S)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n), .dma(dma_if),
    .wr_done_v_i(wr_v), .wr_done_id_i(wr_id), .error_o(error)
  );

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  // Model: outstanding counts, word progress, rotation pointer, read streak,
  // and the cache currently being offered to the bridge (-1 when none).
  int m_out[N], m_words[N], rd_blocks[N];
  int m_total, m_streak, m_rr, m_grant, issued;
  bit m_err;
  bit pend_wr[N];
  int wr_list[$];
  int req_pct, yumi_pct, data_pct, done_pct;
  int wr_pct_c[N];
  bit [N-1:0] req_mask;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_out[i] = 0; m_words[i] = 0; rd_blocks[i] = 0; pend_wr[i] = 0;
    end
    m_total = 0; m_streak = 0; m_rr = 0; m_grant = -1; issued = -1; m_err = 0;
    wr_list.delete();
    dma_if.dma_pkt_i = '0; dma_if.dma_pkt_v_i = '0; dma_if.dma_pkt_yumi_i = '0;
    dma_if.dma_data_v_i = '0; dma_if.dma_data_ready_i = '0;
    wr_v = 1'b0; wr_id = '0;
  endtask

  function automatic logic [63:0] exp_v();
    return (m_grant >= 0) ? (64'd1 << m_grant) : 64'd0;
  endfunction

  task automatic drive_inputs();
    if (issued >= 0) begin
      dma_if.dma_pkt_v_i[issued] = 1'b0;
      issued = -1;
    end
    for (int i = 0; i < N; i++) begin
      if (!dma_if.dma_pkt_v_i[i] && req_mask[i] && ($urandom_range(99) < req_pct)) begin
        pend_wr[i] = ($urandom_range(99) < wr_pct_c[i]);
        dma_if.dma_pkt_i[i] = {pend_wr[i], 32'($urandom)};
        dma_if.dma_pkt_v_i[i] = 1'b1;
      end
    end
    dma_if.dma_pkt_yumi_i = '0;
    if (m_grant >= 0 && ($urandom_range(99) < yumi_pct)) dma_if.dma_pkt_yumi_i[m_grant] = 1'b1;
    for (int i = 0; i < N; i++) begin
      bit dv;
      dv = (rd_blocks[i] > 0) && ($urandom_range(99) < data_pct);
      dma_if.dma_data_v_i[i] = dv;
      dma_if.dma_data_ready_i[i] = dv ? ($urandom_range(3) != 0) : 1'($urandom_range(1));
    end
    wr_v = 1'b0;
    if (wr_list.size() > 0 && ($urandom_range(99) < done_pct)) begin
      int k;
      k = $urandom_range(wr_list.size() - 1);
      wr_id = IDW'(wr_list[k]);
      wr_list.delete(k);
      wr_v = 1'b1;
    end
  endtask

  // Advance the model across the coming clock edge using the inputs just driven.
  task automatic model_step();
    int dec[N];
    int acc, g;
    bit any_wr, starve;
    bit elig[N];
    for (int i = 0; i < N; i++) begin
      dec[i] = 0;
      if (dma_if.dma_data_v_i[i] && dma_if.dma_data_ready_i[i]) begin
        m_words[i]++;
        if (m_words[i] == B) begin
          m_words[i] = 0; dec[i]++;
          if (rd_blocks[i] > 0) rd_blocks[i]--;
        end
      end
    end
    if (wr_v) begin
      if (int'(wr_id) < N) dec[wr_id]++;
      else m_err = 1;
    end
    g = -1;
    if (m_grant >= 0 && dma_if.dma_pkt_yumi_i[m_grant]) g = m_grant;
    any_wr = 0;
    for (int i = 0; i < N; i++) if (dma_if.dma_pkt_v_i[i] && pend_wr[i]) any_wr = 1;
    starve = (m_streak == S) && any_wr;
    for (int i = 0; i < N; i++)
      elig[i] = dma_if.dma_pkt_v_i[i] && (m_out[i] < MAXO) && (m_total < TOT) && !(starve && !pend_wr[i]);
    acc = 0;
    for (int i = 0; i < N; i++) begin
      if (dec[i] > m_out[i]) begin m_err = 1; dec[i] = m_out[i]; end
      m_out[i] = m_out[i] + ((g == i) ? 1 : 0) - dec[i];
      acc += dec[i];
    end
    m_total = m_total + ((g >= 0) ? 1 : 0) - acc;
    if (g >= 0) begin
      if (pend_wr[g]) begin wr_list.push_back(g); m_streak = 0; end
      else begin rd_blocks[g]++; if (m_streak < S) m_streak++; end
      m_rr = (g + 1) % N;
      m_grant = -1;
      issued = g;
    end else if (m_grant < 0) begin
      for (int k = 0; k < N; k++)
        if (m_grant < 0 && elig[(m_rr + k) % N]) m_grant = (m_rr + k) % N;
    end
  endtask

  task automatic cycle();
    chk("v_o", 64'(dma_if.dma_pkt_v_o), exp_v());
    chk("error_o", 64'(error), 64'(m_err));
    chk("v_o_without_v_i", 64'(dma_if.dma_pkt_v_o & ~dma_if.dma_pkt_v_i), 64'd0);
    drive_inputs();
    #1;
    chk("yumi_o", 64'(dma_if.dma_pkt_yumi_o), 64'(dma_if.dma_pkt_yumi_i) & exp_v());
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_phase(input bit [N-1:0] mask, input int rq, input int yu,
                           input int da, input int dn, input int ncyc);
    req_mask = mask; req_pct = rq; yumi_pct = yu; data_pct = da; done_pct = dn;
    for (int c = 0; c < ncyc; c++) cycle();
  endtask

  initial begin
    model_reset();
    wr_pct_c = '{0, 0, 0, 0};
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rst_v_o", 64'(dma_if.dma_pkt_v_o), 64'd0);
    chk("rst_yumi_o", 64'(dma_if.dma_pkt_yumi_o), 64'd0);
    chk("rst_error_o", 64'(error), 64'd0);
    @(negedge clk);

    // Lone read on cache 2: offered one cycle after its valid rises.
    dma_if.dma_pkt_i[2] = {1'b0, 32'h0000_2000};
    dma_if.dma_pkt_v_i[2] = 1'b1;
    run_phase(4'b0000, 0, 0, 0, 0, 1);
    chk("single_read_v_o", 64'(dma_if.dma_pkt_v_o), 64'b0100);
    run_phase(4'b0000, 0, 100, 100, 0, 16);

    // All caches reading continuously with slow data return.
    run_phase(4'b1111, 100, 100, 15, 0, 200);
    run_phase(4'b0000, 0, 100, 100, 0, 60);

    // Writes from cache 1 held without completion, then released.
    wr_pct_c = '{0, 100, 0, 0};
    run_phase(4'b0011, 100, 100, 50, 0, 40);
    run_phase(4'b0011, 100, 100, 50, 40, 60);

    // Reads on 0/1 with an occasional write on 2 exercises the streak limit.
    wr_pct_c = '{0, 0, 100, 0};
    run_phase(4'b0111, 60, 90, 70, 60, 300);

    // Fully random traffic.
    for (int p = 0; p < 20; p++) begin
      for (int i = 0; i < N; i++) wr_pct_c[i] = $urandom_range(100);
      run_phase(4'($urandom_range(15)) | 4'b0001, $urandom_range(100), $urandom_range(20, 100),
                $urandom_range(10, 100), $urandom_range(10, 100), 100);
    end

    // Asynchronous reset while a packet is being offered.
    wr_pct_c = '{0, 0, 0, 0};
    for (int c = 0; c < 60 && m_grant < 0; c++) run_phase(4'b1111, 100, 0, 100, 100, 1);
    chk("grant_before_reset", 64'(m_grant >= 0), 64'd1);
    if (m_grant >= 0) dma_if.dma_pkt_yumi_i[m_grant] = 1'b1;
    #1;
    chk("pre_reset_yumi_o", 64'(dma_if.dma_pkt_yumi_o), exp_v());
    #1 reset_n = 1'b0;
    #1;
    chk("async_rst_v_o", 64'(dma_if.dma_pkt_v_o), 64'd0);
    chk("async_rst_yumi_o", 64'(dma_if.dma_pkt_yumi_o), 64'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;

    // Write completion for cache 0 with nothing outstanding.
    wr_v = 1'b1; wr_id = '0;
    m_err = 1;
    @(posedge clk);
    #1 wr_v = 1'b0;
    @(negedge clk);
    chk("err_after_release", 64'(error), 64'd1);
    run_phase(4'b1111, 100, 100, 100, 100, 40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
